// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: alarm match, ring/snooze/timeout FSM and gated buzzer drive; snooze enabled by ALARM_SNOOZE_EN
module alarm_ring_ctrl #(
  parameter int TONE_DIV    = 25000,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic [3:0] f0,
  input  logic [3:0] f1,
  input  logic [3:0] f2,
  input  logic [3:0] f3,
  input  logic [3:0] j0,
  input  logic [3:0] j1,
  input  logic [3:0] j2,
  input  logic [3:0] j3,
  input  logic       arm,
  input  logic       off,
  input  logic       snooze,
  output logic       sonido,
  output logic       ringing
);
`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RING} state_t;
  logic unused_snooze;
  assign unused_snooze = snooze | (SNOOZE_SECS == 0);
`endif
  state_t      state_q, state_d;
  logic        match, trigger, match_q;
  logic [7:0]  sec_cnt_q, sec_cnt_d;
  logic [15:0] tone_cnt_q, tone_cnt_d;
  logic        tone_q, tone_d, phase_q, phase_d, sonido_q, sonido_d, ringing_q, ringing_d;
  logic        in_ring, wrap, sec_last;
  assign match   = arm && ({f3, f2, f1, f0} == {j3, j2, j1, j0});
  assign trigger = match && !match_q;
  assign sonido  = sonido_q;
  assign ringing = ringing_q;
  // next state: disarm beats off, off beats snooze, snooze beats counter expiry
  always_comb begin
    state_d  = state_q;
    sec_last = tick_1hz && (sec_cnt_q == 8'(RING_SECS - 1));
    if (!arm) state_d = IDLE;
    else if (state_q == IDLE) state_d = trigger ? RING : IDLE;
    else if (off) state_d = IDLE;
`ifdef ALARM_SNOOZE_EN
    else if (state_q == RING && snooze) state_d = SNOOZE;
    else if (state_q == SNOOZE && tick_1hz && sec_cnt_q == 8'(SNOOZE_SECS - 1)) state_d = RING;
`endif
    else if (state_q == RING && sec_last) state_d = IDLE;
  end
  // seconds counter, tone divider, 1 s beep gate and registered outputs
  always_comb begin
    in_ring    = state_q == RING;
    wrap       = tone_cnt_q == 16'(TONE_DIV - 1);
    sec_cnt_d  = (state_d != state_q) ? 8'd0 : (state_q != IDLE && tick_1hz) ? sec_cnt_q + 8'd1 : sec_cnt_q;
    tone_cnt_d = (!in_ring || wrap) ? 16'd0 : tone_cnt_q + 16'd1;
    tone_d     = in_ring && (tone_q ^ wrap);
    phase_d    = (state_d == RING && !in_ring) ? 1'b1 : (in_ring && tick_1hz) ? !phase_q : phase_q;
    sonido_d   = in_ring && phase_q && tone_q;
    ringing_d  = state_d != IDLE;
  end
  // state and datapath registers; match_q resets high so a reset at the alarm minute stays silent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      match_q    <= 1'b1;
      sec_cnt_q  <= 8'd0;
      tone_cnt_q <= 16'd0;
      tone_q     <= 1'b0;
      phase_q    <= 1'b0;
      sonido_q   <= 1'b0;
      ringing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      match_q    <= match;
      sec_cnt_q  <= sec_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
      phase_q    <= phase_d;
      sonido_q   <= sonido_d;
      ringing_q  <= ringing_d;
    end
  end
endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb_alarm_ring_ctrl: vector table, hand sequences and random run against a cycle-count reference model
module tb_alarm_ring_ctrl;
  localparam int TD = 4;
  localparam int RS = 5;
  localparam int SS = 3;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, tick_1hz = 1'b0, arm = 1'b1, off = 1'b0, snooze = 1'b0;
  logic [15:0] tclk = 16'h0000, talm = 16'h0000;
  logic sonido, ringing;
  int total = 0, bad = 0, cyc = 0;
  bit auto_tick = 1'b0;
  int m_mode = 0, m_k = 0, m_ticks = 0;
  bit m_prev = 1'b1, exp_son = 1'b0;
  typedef struct {
    logic [15:0] t;
    logic a, o, s;
    int n;
    logic er;
  } vec_t;
  vec_t tbl[15];
  logic [15:0] times[3];
  alarm_ring_ctrl #(.TONE_DIV(TD), .RING_SECS(RS), .SNOOZE_SECS(SS)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .f0(tclk[3:0]), .f1(tclk[7:4]), .f2(tclk[11:8]), .f3(tclk[15:12]),
    .j0(talm[3:0]), .j1(talm[7:4]), .j2(talm[11:8]), .j3(talm[15:12]),
    .arm(arm), .off(off), .snooze(snooze), .sonido(sonido), .ringing(ringing)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_mode = 0; m_k = 0; m_ticks = 0; m_prev = 1'b1; exp_son = 1'b0;
  endtask
  // model: mode 0 idle, 1 ring, 2 snooze; tone and beep gate derived from cycles and ticks since entry
  task automatic step();
    bit m, trig, ph, tn;
    int nm;
    if (auto_tick) tick_1hz = (cyc % 50 == 49);
    cyc++;
    @(posedge clk);
    m = arm && (tclk == talm);
    trig = m && !m_prev;
    m_prev = m;
    ph = (m_ticks % 2) == 0;
    tn = ((m_k / TD) % 2) == 1;
    exp_son = (m_mode == 1) && ph && tn;
    nm = m_mode;
    if (!arm) nm = 0;
    else if (m_mode == 0) nm = trig ? 1 : 0;
    else if (off) nm = 0;
    else if (SNZ && m_mode == 1 && snooze) nm = 2;
    else if (tick_1hz && m_mode == 1 && m_ticks + 1 == RS) nm = 0;
    else if (tick_1hz && m_mode == 2 && m_ticks + 1 == SS) nm = 1;
    if (nm != m_mode) begin
      m_k = 0; m_ticks = 0;
    end else begin
      m_k++;
      if (tick_1hz && m_mode != 0) m_ticks++;
    end
    m_mode = nm;
    #1;
    chk("model_ringing", ringing, m_mode != 0);
    chk("model_sonido", sonido, exp_son);
    tick_1hz = 1'b0; off = 1'b0; snooze = 1'b0;
  endtask
  task automatic start_ring();
    tclk = 16'h0731; step();
    tclk = 16'h0730; step();
  endtask
  initial begin
    tbl[0]  = '{16'h0729, 1'b1, 1'b0, 1'b0, 3, 1'b0};
    tbl[1]  = '{16'h0730, 1'b1, 1'b0, 1'b0, 1, 1'b1};
    tbl[2]  = '{16'h0730, 1'b1, 1'b0, 1'b0, 6, 1'b1};
    tbl[3]  = '{16'h0730, 1'b1, 1'b1, 1'b0, 1, 1'b0};
    tbl[4]  = '{16'h0730, 1'b1, 1'b0, 1'b0, 5, 1'b0};
    tbl[5]  = '{16'h0731, 1'b1, 1'b0, 1'b0, 2, 1'b0};
    tbl[6]  = '{16'h0730, 1'b1, 1'b0, 1'b0, 1, 1'b1};
    tbl[7]  = '{16'h0730, 1'b0, 1'b0, 1'b0, 1, 1'b0};
    tbl[8]  = '{16'h0730, 1'b1, 1'b0, 1'b0, 1, 1'b1};
    tbl[9]  = '{16'h0730, 1'b1, 1'b1, 1'b1, 1, 1'b0};
    tbl[10] = '{16'h0730, 1'b1, 1'b1, 1'b0, 3, 1'b0};
    tbl[11] = '{16'h0731, 1'b1, 1'b0, 1'b0, 1, 1'b0};
    tbl[12] = '{16'h0730, 1'b1, 1'b0, 1'b1, 1, 1'b1};
    tbl[13] = '{16'h0730, 1'b1, 1'b0, 1'b1, 1, 1'b1};
    tbl[14] = '{16'h0730, 1'b1, 1'b1, 1'b0, 1, 1'b0};
    times[0] = 16'h0729; times[1] = 16'h0730; times[2] = 16'h0731;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    chk("reset_sonido", sonido, 1'b0);
    chk("reset_ringing", ringing, 1'b0);
    repeat (4) step();
    chk("reset_equal_no_ring", ringing, 1'b0);
    talm = 16'h0730;
    for (int i = 0; i < 15; i++) begin
      tclk = tbl[i].t; arm = tbl[i].a; off = tbl[i].o; snooze = tbl[i].s;
      repeat (tbl[i].n) step();
      chk($sformatf("tbl%0d", i), ringing, tbl[i].er);
    end
    start_ring();
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("beep_k%0d", k), sonido, ((k - 1) / TD) % 2 == 1);
    end
    off = 1'b1; step();
    chk("off_ringing", ringing, 1'b0);
    step();
    chk("off_sonido", sonido, 1'b0);
    start_ring();
    for (int t = 1; t <= RS; t++) begin
      repeat (3) step();
      tick_1hz = 1'b1; step();
      chk($sformatf("timeout_tick%0d", t), ringing, t < RS);
    end
    start_ring();
    snooze = 1'b1; step();
    chk("snooze_ringing", ringing, 1'b1);
`ifdef ALARM_SNOOZE_EN
    step();
    chk("snooze_silent", sonido, 1'b0);
    for (int t = 1; t <= SS; t++) begin
      repeat (2) step();
      tick_1hz = 1'b1; step();
      chk($sformatf("snooze_tick%0d", t), ringing, 1'b1);
    end
    repeat (5) step();
    chk("snooze_resume_beep", sonido, 1'b1);
    snooze = 1'b1; step();
    off = 1'b1; step();
    chk("snooze_off", ringing, 1'b0);
`else
    repeat (4) step();
    chk("snooze_ignored_beep", sonido, 1'b1);
    off = 1'b1; step();
    chk("snooze_ignored_off", ringing, 1'b0);
`endif
    start_ring();
    repeat (5) step();
    chk("pre_reset_sonido", sonido, 1'b1);
    rst_n = 1'b0;
    #2;
    chk("async_rst_sonido", sonido, 1'b0);
    chk("async_rst_ringing", ringing, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    repeat (3) step();
    chk("no_resume_after_reset", ringing, 1'b0);
    auto_tick = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      arm = $urandom_range(0, 199) != 0;
      if ($urandom_range(0, 39) == 0) tclk = times[$urandom_range(0, 2)];
      off = $urandom_range(0, 99) == 0;
      snooze = $urandom_range(0, 59) == 0;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alarm_ring_ctrl.md
# alarm_ring_ctrl

Downstream consumer of the alarm clock's time and alarm-setpoint digits. Compares the running clock (BCD HH:MM) against the alarm setpoint and drives the buzzer output. It owns the complete ring life cycle: trigger on match, gated beep pattern, manual off, snooze, and auto-timeout. It sits beside the display path: it takes the same four clock digits and four alarm digits the display multiplexer sees, and `sonido` drives the pin directly.

## Interface

Parameters:
- `TONE_DIV`, 25000: clk cycles per tone half-period. Range 1..65535.
- `RING_SECS`, 60: seconds of continuous ringing before auto-stop. Range 1..255.
- `SNOOZE_SECS`, 120: snooze length in seconds. Range 1..255; used only with the macro in Configuration.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `tick_1hz`, in, 1: one-cycle pulse once per second, synchronous to `clk`.
- `f0`,`f1`,`f2`,`f3`, in, 4 each: clock digits (minute units, minute tens, hour units, hour tens), BCD.
- `j0`,`j1`,`j2`,`j3`, in, 4 each: alarm setpoint digits, same order.
- `arm`, in, 1: alarm enabled; level.
- `off`, in, 1: debounced single-cycle pulse; stops ringing.
- `snooze`, in, 1: debounced single-cycle pulse.
- `sonido`, out, 1: buzzer drive, registered.
- `ringing`, out, 1: high in RING or SNOOZE, registered.

## Operation

- `match` = `arm` AND all eight digits equal pairwise. This is combinational.
- `match_q` is a registered copy of `match`. Its reset value is 1, so a reset while the times are equal never rings.
- A trigger is `match & ~match_q`, i.e. a rising edge only. Once `off` clears a ring, the same minute cannot retrigger it.
- States:
  - IDLE, to RING on a trigger.
  - RING:
    - to IDLE on `off`;
    - to IDLE on timeout;
    - to SNOOZE on `snooze` (macro only).
  - SNOOZE:
    - to IDLE on `off`;
    - to RING when the snooze count expires.
- From any state, `arm`=0 forces IDLE on the next edge.
- Priority: `arm`=0, then `off`, then `snooze`, then counter expiry. Triggers are ignored outside IDLE.
- `sec_cnt` is 8 bits.
  - It clears on every state entry.
  - It increments on `tick_1hz` in RING and SNOOZE.
  - In RING, a tick with `sec_cnt`==`RING_SECS`-1 is the timeout.
  - In SNOOZE, a tick with `sec_cnt`==`SNOOZE_SECS`-1 is expiry.
- Tone generator:
  - A 16-bit counter wraps at `TONE_DIV`-1 and toggles `tone` on the wrap.
  - It runs only in RING and is held at 0 with `tone`=0 otherwise.
- Beep gate:
  - `phase` is set to 1 on every RING entry.
  - It toggles on each `tick_1hz` in RING.
  - The result is 1 s on, 1 s off.
- `sonido` = registered (RING & `phase` & `tone`).

## Timing

- Reset values: state IDLE, `sonido`=0, `ringing`=0, `match_q`=1, `sec_cnt`=0, tone counter 0, `tone`=0, `phase`=0.
- Trigger latency: the digits change to the setpoint at edge N. The state is RING at edge N+1, and `ringing`=1 after edge N+1.
- First `tone` rise: `TONE_DIV` cycles after RING entry. `sonido` follows `tone` with one register stage.
- `off` seen at edge N: state is IDLE and `ringing`=0 after edge N, and `sonido`=0 after edge N+1.
- Timeout: the RING_SECS-th tick after RING entry returns to IDLE on that edge.
- `off` and `snooze` in the same cycle: `off` wins.
- `off` in IDLE: no effect.
- An asynchronous reset mid-ring clears everything immediately. The ring does not resume after reset, because `match_q`=1.

## Configuration

- `ALARM_SNOOZE_EN` defined:
  - The SNOOZE state, the `snooze` input and `SNOOZE_SECS` are active.
- `ALARM_SNOOZE_EN` undefined:
  - The `snooze` port still exists but is ignored, and no SNOOZE state is synthesised.
  - RING exits only by `off`, timeout or `arm`=0.

## Test plan

Bench settings: `TONE_DIV`=4, `RING_SECS`=5, `SNOOZE_SECS`=3, `tick_1hz` every 50 cycles.

- Trigger:
  - Stimulus: `arm`=1, alarm 07:30, clock steps 07:29 to 07:30.
  - Response: `ringing`=1 one edge later. `sonido` toggles every 4 cycles during the on-second and stays 0 during the off-second.
- Off and no retrigger:
  - Stimulus: pulse `off` during the ring, clock held at 07:30.
  - Response: IDLE, `sonido`=0 within 2 edges, no retrigger for the rest of that minute.
  - Follow-up: clock 07:30 to 07:31 to 07:30. Response: rings again.
- Timeout: no `off`. Response: `ringing` falls on the 5th tick after entry.
- Snooze (macro on):
  - Stimulus: `snooze` during the ring.
  - Response: `sonido`=0 and `ringing`=1. After 3 ticks it is back in RING with `phase`=1. `off` in SNOOZE goes to IDLE.
  - Simultaneous `off`+`snooze`: goes to IDLE.
- Snooze (macro off): `snooze` during the ring is ignored and ringing continues.
- Reset and disarm:
  - Reset released with clock = alarm = 00:00: no ring.
  - `arm` dropped during RING: IDLE on the next edge.
  - `rst_n` low mid-ring: `sonido`=0 and `ringing`=0 asynchronously.
